// File: rtl/sh7034_ibus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sh7034_ibus_arb_pkg
// Description : Shared SH7034 internal-bus types: access sizes, arbiter
//               states, master IDs and the alignment rule.
// Revision    : 1.0  initial release
// ============================================================================
package sh7034_ibus_arb_pkg;

  // Access size as presented by a master on its SZ port
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2,
    SZ_RSVD = 2'd3
  } sz_e;

  // Arbiter / bus-cycle state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Bus master identifier
  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_e;

  // True when the request may not reach the bus (reserved size or misaligned)
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    logic bad;
    case (sz)
      SZ_WORD: bad = a_lo[0];
      SZ_LONG: bad = (a_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sh7034_ibus_lane.sv
`default_nettype none
// ============================================================================
// Module      : sh7034_ibus_lane
// Description : Big-endian byte-lane logic. Write mode replicates right-
//               justified data onto the lanes; read mode extracts the addressed
//               lane(s) into a right-justified, zero-extended word. Both modes
//               produce the lane-enable mask.
// Revision    : 1.0  initial release
// ============================================================================
module sh7034_ibus_lane
  import sh7034_ibus_arb_pkg::*;
#(
  parameter bit IS_READ = 1'b0
) (
  input  logic [1:0]  a_lo_i,
  input  logic [1:0]  sz_i,
  input  logic [31:0] data_i,
  output logic [3:0]  ba_o,
  output logic [31:0] data_o
);

  // Lane enables; BA[3] is the byte at offset 0
  always_comb begin
    case (sz_i)
      SZ_BYTE: ba_o = 4'b1000 >> a_lo_i;
      SZ_WORD: ba_o = a_lo_i[1] ? 4'b0011 : 4'b1100;
      SZ_LONG: ba_o = 4'b1111;
      default: ba_o = 4'b0000;
    endcase
  end

  if (IS_READ) begin : g_read
    logic [1:0] lane;
    // Pull the addressed lane(s) down to the low end, zero-fill the rest
    always_comb begin
      data_o = '0;
      lane   = 2'd3 - a_lo_i;
      case (sz_i)
        SZ_BYTE: data_o[7:0]  = data_i[{lane, 3'b000} +: 8];
        SZ_WORD: data_o[15:0] = a_lo_i[1] ? data_i[15:0] : data_i[31:16];
        SZ_LONG: data_o       = data_i;
        default: data_o       = '0;
      endcase
    end
  end else begin : g_write
    // Replicate so whichever lane is enabled carries the data
    always_comb begin
      case (sz_i)
        SZ_BYTE: data_o = {4{data_i[7:0]}};
        SZ_WORD: data_o = {2{data_i[15:0]}};
        SZ_LONG: data_o = data_i;
        default: data_o = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sh7034_ibus_arb.sv
`default_nettype none
// ============================================================================
// Module      : sh7034_ibus_arb
// Description : Two-master (CPU, DMA) internal-bus arbiter. Grants on the
//               rising phase, runs an ACC/DATA bus cycle, rejects misaligned
//               accesses with an error pulse and alternates under contention.
// Revision    : 1.0  initial release
// ============================================================================
module sh7034_ibus_arb
  import sh7034_ibus_arb_pkg::*;
#(
  parameter bit DMA_PRIO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_r_i,
  input  logic        ce_f_i,
  input  logic [27:0] cpu_a_i,
  input  logic [31:0] cpu_di_i,
  input  logic [1:0]  cpu_sz_i,
  input  logic        cpu_we_i,
  input  logic        cpu_req_i,
  output logic [31:0] cpu_do_o,
  output logic        cpu_busy_o,
  output logic        cpu_err_o,
  input  logic [27:0] dma_a_i,
  input  logic [31:0] dma_di_i,
  input  logic [1:0]  dma_sz_i,
  input  logic        dma_we_i,
  input  logic        dma_req_i,
  output logic [31:0] dma_do_o,
  output logic        dma_busy_o,
  output logic        dma_err_o,
  output logic [27:0] ibus_a_o,
  output logic [31:0] ibus_do_o,
  output logic [3:0]  ibus_ba_o,
  output logic        ibus_we_o,
  output logic        ibus_req_o,
  input  logic [31:0] ibus_di_i,
  input  logic        ibus_busy_i,
  input  logic        ibus_act_i
);

  localparam mst_e PRIO_MST = DMA_PRIO ? MST_DMA : MST_CPU;

  state_e      state_q;
  mst_e        gnt_q, ptr_q, ptr_d, win;
  logic [1:0]  lat_lo_q, lat_sz_q;
  logic        act_q;
  logic        cpu_done_q, dma_done_q, cpu_err_q, dma_err_q;
  logic [31:0] cpu_do_q, dma_do_q;
  logic        ibus_req_q, ibus_we_q;
  logic [3:0]  ibus_ba_q;
  logic [27:0] ibus_a_q;
  logic [31:0] ibus_do_q;

  logic [27:0] sel_a;
  logic [31:0] sel_di;
  logic [1:0]  sel_sz;
  logic        sel_we, sel_bad, any_req;
  logic [3:0]  wr_ba, rd_ba_unused;
  logic [31:0] wr_data, rd_data;

  // Pick the winner: the fairness pointer decides only under contention
  always_comb begin
    any_req = cpu_req_i | dma_req_i;
    if (cpu_req_i && dma_req_i) begin
      win   = ptr_q;
      ptr_d = (ptr_q == MST_DMA) ? MST_CPU : MST_DMA;
    end else begin
      win   = dma_req_i ? MST_DMA : MST_CPU;
      ptr_d = PRIO_MST;
    end
    if (win == MST_DMA) begin
      sel_a  = dma_a_i;
      sel_di = dma_di_i;
      sel_sz = dma_sz_i;
      sel_we = dma_we_i;
    end else begin
      sel_a  = cpu_a_i;
      sel_di = cpu_di_i;
      sel_sz = cpu_sz_i;
      sel_we = cpu_we_i;
    end
    sel_bad = misaligned(sel_sz, sel_a[1:0]);
  end

  sh7034_ibus_lane #(.IS_READ(1'b0)) u_lane_wr (
    .a_lo_i (sel_a[1:0]),
    .sz_i   (sel_sz),
    .data_i (sel_di),
    .ba_o   (wr_ba),
    .data_o (wr_data)
  );

  sh7034_ibus_lane #(.IS_READ(1'b1)) u_lane_rd (
    .a_lo_i (lat_lo_q),
    .sz_i   (lat_sz_q),
    .data_i (ibus_di_i),
    .ba_o   (rd_ba_unused),
    .data_o (rd_data)
  );

  // Bus-cycle FSM with registered bus and master outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= PRIO_MST;
      ptr_q      <= PRIO_MST;
      lat_lo_q   <= '0;
      lat_sz_q   <= '0;
      act_q      <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      cpu_err_q  <= 1'b0;
      dma_err_q  <= 1'b0;
      cpu_do_q   <= '0;
      dma_do_q   <= '0;
      ibus_req_q <= 1'b0;
      ibus_we_q  <= 1'b0;
      ibus_ba_q  <= '0;
      ibus_a_q   <= '0;
      ibus_do_q  <= '0;
    end else begin
      cpu_err_q <= 1'b0;
      dma_err_q <= 1'b0;
      if (ce_r_i) begin
        cpu_done_q <= 1'b0;
        dma_done_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (ce_r_i && any_req) begin
            ptr_q <= ptr_d;
            if (sel_bad) begin
              // Rejected before it reaches the bus: complete with an error now
              if (win == MST_DMA) begin
                dma_err_q  <= 1'b1;
                dma_do_q   <= '0;
                dma_done_q <= 1'b1;
              end else begin
                cpu_err_q  <= 1'b1;
                cpu_do_q   <= '0;
                cpu_done_q <= 1'b1;
              end
            end else begin
              state_q    <= ST_ACC;
              gnt_q      <= win;
              lat_lo_q   <= sel_a[1:0];
              lat_sz_q   <= sel_sz;
              ibus_req_q <= 1'b1;
              ibus_we_q  <= sel_we;
              ibus_a_q   <= {sel_a[27:2], 2'b00};
              ibus_ba_q  <= wr_ba;
              ibus_do_q  <= wr_data;
            end
          end
        end
        ST_ACC: begin
          if (ce_r_i && !ibus_busy_i) begin
            state_q    <= ST_DATA;
            act_q      <= ibus_act_i;
            ibus_req_q <= 1'b0;
            ibus_we_q  <= 1'b0;
            ibus_ba_q  <= '0;
          end
        end
        ST_DATA: begin
          if (ce_f_i) begin
            // A slave that did not decode the address yields a bus error
            state_q <= ST_IDLE;
            if (gnt_q == MST_DMA) begin
              dma_done_q <= 1'b1;
              dma_do_q   <= act_q ? rd_data : '0;
              dma_err_q  <= ~act_q;
            end else begin
              cpu_done_q <= 1'b1;
              cpu_do_q   <= act_q ? rd_data : '0;
              cpu_err_q  <= ~act_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_busy_o = cpu_req_i & ~cpu_done_q;
  assign dma_busy_o = dma_req_i & ~dma_done_q;
  assign cpu_do_o   = cpu_do_q;
  assign dma_do_o   = dma_do_q;
  assign cpu_err_o  = cpu_err_q;
  assign dma_err_o  = dma_err_q;
  assign ibus_req_o = ibus_req_q;
  assign ibus_we_o  = ibus_we_q;
  assign ibus_ba_o  = ibus_ba_q;
  assign ibus_a_o   = ibus_a_q;
  assign ibus_do_o  = ibus_do_q;

endmodule
`default_nettype wire
